// File: rtl/mem_arbiter_if.sv
// Avalon-MM style bus bundle shared by both masters and the mem_if slave side.
// Modports: master drives the request side, slave drives the response side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdataready;
    logic                  waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, readdataready, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, readdataready, waitrequest
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of mem_if: round-robin grants with a per-grant
// hold limit, and an in-order tag FIFO routing read responses to their issuer.
// Ports: clock, reset_n (async, active-low); m0 (read-only stimulus master,
// write/writedata ignored) and m1 (read/write log master) as slave modports;
// s as master modport towards mem_if; err_orphan sticky flag.
// Option: define MEM_ARB_FIXED_PRIO_EN for strict master-0 priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int HOLD_MAX   = 8,
    parameter int TAG_DEPTH  = 4,
    parameter int TAG_PTR_W  = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic          err_orphan
);
    localparam int HC_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic                   last_grant;
    logic [HC_W-1:0]        hold_cnt, hold_next;
    logic [TAG_DEPTH-1:0]   tag_mem;
    logic [TAG_PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [TAG_PTR_W:0]     count;

    logic req0, req1;
    logic full, empty, tag_block;
    logic push, pop, accept, head;
    logic at_limit;
    logic unused_m0;

    assign unused_m0 = m0.write | (|m0.writedata);

    assign req0 = m0.read;
    assign req1 = m1.read | m1.write;

    assign full  = (count == (TAG_PTR_W + 1)'(TAG_DEPTH));
    assign empty = (count == '0);
    // A response popping this cycle frees a slot, so a read may go out now.
    assign tag_block = full & ~s.readdataready;

    assign accept = (s.read | s.write) & ~s.waitrequest;
    assign push   = s.read & ~s.waitrequest;
    assign pop    = s.readdataready & ~empty;
    assign head   = tag_mem[rd_ptr];

    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdataready = pop & ~head;
    assign m1.readdataready = pop & head;

    // Leave decision sees the count including this cycle's transfer, so
    // exactly HOLD_MAX transfers are accepted per contended grant.
    assign hold_next = hold_cnt + HC_W'(accept && (hold_cnt != HC_W'(HOLD_MAX)));
    assign at_limit  = (hold_next == HC_W'(HOLD_MAX));

    always_comb begin
        s.address      = '0;
        s.byteenable   = '0;
        s.read         = 1'b0;
        s.write        = 1'b0;
        s.writedata    = '0;
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        unique case (state)
            GRANT0: begin
                s.address      = m0.address;
                s.byteenable   = m0.byteenable;
                s.read         = m0.read & ~tag_block;
                m0.waitrequest = s.waitrequest | (m0.read & tag_block);
            end
            GRANT1: begin
                s.address      = m1.address;
                s.byteenable   = m1.byteenable;
                s.read         = m1.read & ~tag_block;
                s.write        = m1.write;
                s.writedata    = m1.writedata;
                m1.waitrequest = s.waitrequest | (m1.read & tag_block);
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_grant;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            GRANT0: begin
                if (!req0)
                    state_next = req1 ? GRANT1 : IDLE;
                else if (at_limit && req1)
                    state_next = GRANT1;
            end
            GRANT1: begin
                if (!req1)
                    state_next = req0 ? GRANT0 : IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
                else if (req0 && accept)
                    state_next = GRANT0;
`else
                else if (at_limit && req0)
                    state_next = GRANT0;
`endif
            end
            default: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                if (req0)
                    state_next = GRANT0;
`else
                if (req0 && (!req1 || last_grant))
                    state_next = GRANT0;
`endif
                else if (req1)
                    state_next = GRANT1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                hold_cnt <= '0;
                if (state == GRANT0)
                    last_grant <= 1'b0;
                else if (state == GRANT1)
                    last_grant <= 1'b1;
            end else begin
                hold_cnt <= hold_next;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_mem    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= (state == GRANT1);
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (s.readdataready && empty)
                err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, scoreboarded read routing,
// round-robin hold pattern, tag-full stall, orphan responses and priority.
module tb_mem_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic err_orphan;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m0_bus();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m1_bus();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) s_bus();

    mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .HOLD_MAX(8), .TAG_DEPTH(4), .TAG_PTR_W(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .m0(m0_bus),
        .m1(m1_bus),
        .s(s_bus),
        .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    typedef struct { int due; logic [DW-1:0] data; } pend_t;
    typedef struct { logic id; logic [DW-1:0] data; } exp_t;
    typedef struct {
        logic r0, r1, w1, sw;
        logic ew0, ew1, esr, esw;
    } vec_t;

    pend_t pend[$];
    exp_t  exp_q[$];
    int    acc_log[$];
    int    rsp_log[$];
    int    acc_cnt[2];
    int    rsp_cnt[2];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    logic  hold_resp = 1'b0;
    logic  orphan_pulse = 1'b0;
    logic  sn_w0, sn_w1, sn_sread, sn_swrite, sn_rdr0, sn_rdr1, sn_a0, sn_a1;

    function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_masters();
        m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0;
        m0_bus.byteenable = '1; m0_bus.writedata = '0;
        m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0;
        m1_bus.byteenable = '1; m1_bus.writedata = '0;
        s_bus.waitrequest = 1'b0; s_bus.readdataready = 1'b0;
        s_bus.readdata = '0;
        hold_resp = 1'b0; orphan_pulse = 1'b0;
    endtask

    task automatic do_reset(input bit keep_pend);
        idle_masters();
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_w0", m0_bus.waitrequest, 1);
        chk("rst_w1", m1_bus.waitrequest, 1);
        chk("rst_sread", s_bus.read, 0);
        chk("rst_swrite", s_bus.write, 0);
        chk("rst_rdr", {m1_bus.readdataready, m0_bus.readdataready}, 0);
        chk("rst_orphan", err_orphan, 0);
        exp_q.delete();
        if (!keep_pend) pend.delete();
        acc_log.delete();
        rsp_log.delete();
        acc_cnt = '{0, 0};
        rsp_cnt = '{0, 0};
        reset_n = 1'b1;
    endtask

    // Called at a falling edge with master inputs already set; samples just
    // before the rising edge and returns at the next falling edge.
    task automatic tick();
        exp_t e;
        logic [DW-1:0] d;
        s_bus.readdataready = 1'b0;
        if (orphan_pulse) begin
            s_bus.readdataready = 1'b1;
            s_bus.readdata = 16'hDEAD;
            orphan_pulse = 1'b0;
        end else if (!hold_resp && pend.size() > 0 && pend[0].due <= cyc) begin
            s_bus.readdataready = 1'b1;
            s_bus.readdata = pend[0].data;
            void'(pend.pop_front());
        end
        #4;
        sn_w0 = m0_bus.waitrequest;
        sn_w1 = m1_bus.waitrequest;
        sn_sread = s_bus.read;
        sn_swrite = s_bus.write;
        sn_rdr0 = m0_bus.readdataready;
        sn_rdr1 = m1_bus.readdataready;
        sn_a0 = m0_bus.read & ~m0_bus.waitrequest;
        sn_a1 = (m1_bus.read | m1_bus.write) & ~m1_bus.waitrequest;
        if (s_bus.readdataready) begin
            if (exp_q.size() == 0) begin
                chk("orphan_route", {sn_rdr1, sn_rdr0}, 0);
            end else begin
                e = exp_q.pop_front();
                rsp_log.push_back(int'(e.id));
                rsp_cnt[e.id]++;
                chk("route", {sn_rdr1, sn_rdr0}, e.id ? 2 : 1);
                chk("rdata", e.id ? m1_bus.readdata : m0_bus.readdata, e.data);
            end
        end else begin
            chk("no_rdr", {sn_rdr1, sn_rdr0}, 0);
        end
        chk("single_accept", sn_a0 & sn_a1, 0);
        chk("fwd_accept", (s_bus.read | s_bus.write) & ~s_bus.waitrequest, sn_a0 | sn_a1);
        if (sn_a0) begin
            chk("s_addr0", s_bus.address, m0_bus.address);
            chk("s_rd0", {s_bus.write, s_bus.read}, 1);
            d = fdat(m0_bus.address);
            pend.push_back('{cyc + 2, d});
            exp_q.push_back('{1'b0, d});
            acc_log.push_back(0);
            acc_cnt[0]++;
        end
        if (sn_a1) begin
            chk("s_addr1", s_bus.address, m1_bus.address);
            if (m1_bus.read) begin
                chk("s_rd1", {s_bus.write, s_bus.read}, 1);
                d = fdat(m1_bus.address);
                pend.push_back('{cyc + 2, d});
                exp_q.push_back('{1'b1, d});
            end else begin
                chk("s_wr1", {s_bus.write, s_bus.read}, 2);
                chk("s_wdata1", s_bus.writedata, m1_bus.writedata);
            end
            acc_log.push_back(1);
            acc_cnt[1]++;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic advance();
        if (sn_a0) m0_bus.address = m0_bus.address + 1'b1;
        if (sn_a1) begin
            m1_bus.address = m1_bus.address + 1'b1;
            m1_bus.writedata = m1_bus.writedata + 16'h0101;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int n1;
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        idle_masters();

        // grant decisions from IDLE, one registered cycle of latency
        for (int i = 0; i < 6; i++) begin
            do_reset(0);
            m0_bus.read = vt[i].r0;
            m1_bus.read = vt[i].r1;
            m1_bus.write = vt[i].w1;
            s_bus.waitrequest = vt[i].sw;
            tick();
            chk("tbl_idle_w", {sn_w1, sn_w0}, 3);
            chk("tbl_idle_s", {sn_swrite, sn_sread}, 0);
            tick();
            chk("tbl_w0", sn_w0, vt[i].ew0);
            chk("tbl_w1", sn_w1, vt[i].ew1);
            chk("tbl_sread", sn_sread, vt[i].esr);
            chk("tbl_swrite", sn_swrite, vt[i].esw);
        end

        // m0 alone reads 0..5 with 2-cycle response latency
        do_reset(0);
        for (int i = 0; i < 30; i++) begin
            m0_bus.read = (m0_bus.address < 6);
            tick();
            if (i == 0) chk("t1_idle_w0", sn_w0, 1);
            if (i == 1) chk("t1_grant_w0", sn_w0, 0);
            advance();
        end
        chk("t1_acc0", acc_cnt[0], 6);
        chk("t1_rsp0", rsp_cnt[0], 6);
        chk("t1_rsp1", rsp_cnt[1], 0);
        chk("t1_pend", pend.size(), 0);

        // both request continuously: hold-limited alternation
        do_reset(0);
        m0_bus.read = 1'b1;
        m1_bus.write = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            advance();
        end
        m0_bus.read = 1'b0;
        m1_bus.write = 1'b0;
        repeat (10) tick();
        chk("t2_len_ok", acc_log.size() >= 32, 1);
        for (int i = 0; i < 32 && i < acc_log.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk("t2_order", acc_log[i], (i % 9 == 8) ? 1 : 0);
`else
            chk("t2_order", acc_log[i], (i / 8) % 2);
`endif
        end
        chk("t2_rsp0", rsp_cnt[0], acc_cnt[0]);

        // four reads outstanding block the fifth until a response pops
        do_reset(0);
        hold_resp = 1'b1;
        m0_bus.read = 1'b1;
        for (int i = 0; i < 20 && acc_cnt[0] < 4; i++) begin
            tick();
            advance();
        end
        chk("t3_acc4", acc_cnt[0], 4);
        repeat (2) begin
            tick();
            chk("t3_stall_w0", sn_w0, 1);
            chk("t3_stall_sread", sn_sread, 0);
        end
        hold_resp = 1'b0;
        tick();
        chk("t3_rel_rdr0", sn_rdr0, 1);
        chk("t3_rel_w0", sn_w0, 0);
        chk("t3_rel_acc", sn_a0, 1);
        advance();
        m0_bus.read = 1'b0;
        repeat (10) tick();
        chk("t3_rsp0", rsp_cnt[0], 5);

        // pending m0 reads survive a switch to m1 write then m1 read
        do_reset(0);
        hold_resp = 1'b1;
        m0_bus.read = 1'b1;
        for (int i = 0; i < 20 && acc_cnt[0] < 2; i++) begin
            tick();
            advance();
        end
        m0_bus.read = 1'b0;
        m1_bus.write = 1'b1;
        m1_bus.address = 20'h00100;
        for (int i = 0; i < 20 && acc_cnt[1] < 1; i++) begin
            tick();
            advance();
        end
        m1_bus.write = 1'b0;
        m1_bus.read = 1'b1;
        for (int i = 0; i < 20 && acc_cnt[1] < 2; i++) begin
            tick();
            advance();
        end
        m1_bus.read = 1'b0;
        hold_resp = 1'b0;
        repeat (10) tick();
        chk("t4_acc1", acc_cnt[1], 2);
        chk("t4_nrsp", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            chk("t4_r0", rsp_log[0], 0);
            chk("t4_r1", rsp_log[1], 0);
            chk("t4_r2", rsp_log[2], 1);
        end

        // orphan response is flagged and sticky until reset
        do_reset(0);
        orphan_pulse = 1'b1;
        tick();
        tick();
        chk("t5_orphan_set", err_orphan, 1);
        repeat (5) tick();
        chk("t5_orphan_hold", err_orphan, 1);
        hold_resp = 1'b1;
        m0_bus.read = 1'b1;
        for (int i = 0; i < 20 && acc_cnt[0] < 2; i++) begin
            tick();
            advance();
        end
        do_reset(1);
        chk("t5_orphan_clr", err_orphan, 0);
        repeat (6) tick();
        chk("t5_lost_tag", err_orphan, 1);

        // m1 writing, m0 raises a read
        do_reset(0);
        m1_bus.write = 1'b1;
        for (int i = 0; i < 20 && acc_cnt[1] < 3; i++) begin
            tick();
            advance();
        end
        m0_bus.read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            advance();
        end
        m0_bus.read = 1'b0;
        m1_bus.write = 1'b0;
        repeat (8) tick();
        n1 = 0;
        while (n1 < acc_log.size() && acc_log[n1] == 1) n1++;
        chk("t6_m0_got", n1 < acc_log.size(), 1);
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("t6_m1_run", n1, 4);
`else
        chk("t6_m1_run", n1, 8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
